axilite_noc_request: RTL and testbench

- Upstream neighbour of the NoC-response/AXI-lite return path.
- Accepts AXI-lite read (AR) and write (AW+W) requests and serialises each into a NoC request message: three header flits, plus data flits for stores.
- For every accepted request, pushes a 3-bit transaction-type record into the response block's type FIFO, so responses are steered to the R or B channel in request order.
- Bounds in-flight requests with an outstanding counter.

---
 rtl/axilite_noc_request_if.sv | 58 +++++
 rtl/axilite_noc_request.sv | 203 ++++++++++++++++++++
 tb/tb_axilite_noc_request.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite_noc_request_if.sv
// Bus bundle for axilite_noc_request: AXI-lite AR/AW/W slave side, NoC flit output,
// response type-FIFO push, retire pulse and busy. Also carries the NoC message field map.
`ifndef AXILITE_NOC_REQUEST_DEFINES
`define AXILITE_NOC_REQUEST_DEFINES
`define NOC_DATA_WIDTH         64
`define MSG_DST_CHIPID         63:50
`define MSG_DST_X              49:42
`define MSG_DST_Y              41:34
`define MSG_DST_FBITS          33:30
`define MSG_LENGTH             29:22
`define MSG_TYPE               21:14
`define MSG_MSHRID             13:6
`define MSG_ADDR_              55:16
`define MSG_SRC_CHIPID_        63:50
`define MSG_SRC_X_             49:42
`define MSG_SRC_Y_             41:34
`define MSG_DATA_SIZE_         29:27
`define MSG_TYPE_NC_LOAD_REQ   8'd14
`define MSG_TYPE_NC_STORE_REQ  8'd15
`endif

interface axilite_noc_request_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int NOC_W  = `NOC_DATA_WIDTH
);
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic                noc_valid_out;
    logic [NOC_W-1:0]    noc_data_out;
    logic                noc_ready_in;
    logic [2:0]          transaction_type_wr_data;
    logic                transaction_type_wr;
    logic                txn_retire;
    logic                busy;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_araddr, s_axi_arvalid, noc_ready_in, txn_retire,
        output s_axi_awready, s_axi_wready, s_axi_arready, noc_valid_out, noc_data_out,
               transaction_type_wr_data, transaction_type_wr, busy
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_araddr, s_axi_arvalid, noc_ready_in, txn_retire,
        input  s_axi_awready, s_axi_wready, s_axi_arready, noc_valid_out, noc_data_out,
               transaction_type_wr_data, transaction_type_wr, busy
    );
endinterface

// File: rtl/axilite_noc_request.sv
// AXI-lite request side: serialises AR / AW+W into NoC NC load/store messages and logs the
// request type for the response path. Optional AXI_NOC_WSTRB_SIZE_EN derives store size from wstrb.
module axilite_noc_request #(
    parameter int          AXI_LITE_ADDR_WIDTH = 64,
    parameter int          AXI_LITE_DATA_WIDTH = 64,
    parameter int          MAX_OUTSTANDING     = 16,
    parameter logic [13:0] DEST_CHIPID         = 14'd0,
    parameter logic [7:0]  DEST_X              = 8'd0,
    parameter logic [7:0]  DEST_Y              = 8'd0,
    parameter logic [3:0]  DEST_FBITS          = 4'b0010,
    parameter logic [13:0] SRC_CHIPID          = 14'd0,
    parameter logic [7:0]  SRC_X               = 8'd0,
    parameter logic [7:0]  SRC_Y               = 8'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    axilite_noc_request_if.slave  bus
);

    localparam int NOC_W      = `NOC_DATA_WIDTH;
    localparam int DATA_FLITS = AXI_LITE_DATA_WIDTH / NOC_W;
    localparam int STRB_W     = AXI_LITE_DATA_WIDTH / 8;
    localparam int OFF_W      = $clog2(STRB_W);
    localparam int IDX_W      = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
    localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [7:0] LOAD_LEN  = 8'd2;
    localparam logic [7:0] STORE_LEN = 8'(2 + DATA_FLITS);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_e;

    state_e                         state_q, state_d;
    logic                           rd_pri_q, rd_pri_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_LITE_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]              wstrb_q, wstrb_d;
    logic                           is_store_q, is_store_d;
    logic [IDX_W-1:0]               idx_q, idx_d;

    logic             can_accept, wr_cand, rd_cand, grant_rd, grant_wr, flit_acc;
    logic             inc, dec;
    int               size_lg;
    logic [OFF_W-1:0] byte_off;
    logic [39:0]      msg_addr;
    logic [NOC_W-1:0] data_slice, flit;
    logic             unused_bits;

    function automatic logic [STRB_W-1:0] run_mask(input int lg, input int off);
        logic [STRB_W-1:0] m;
        m = '0;
        for (int b = 0; b < STRB_W; b++)
            if (b >= off && b < off + (1 << lg)) m[b] = 1'b1;
        return m;
    endfunction

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_cand    = bus.s_axi_awvalid && bus.s_axi_wvalid;
        rd_cand    = bus.s_axi_arvalid;
        can_accept = (state_q == IDLE) && (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !reset;
        grant_rd   = can_accept && rd_cand && (!wr_cand || rd_pri_q);
        grant_wr   = can_accept && wr_cand && (!rd_cand || !rd_pri_q);
    end

    // AW and W are granted together so a write address never arrives without its data.
    assign bus.s_axi_arready = grant_rd;
    assign bus.s_axi_awready = grant_wr;
    assign bus.s_axi_wready  = grant_wr;
    assign bus.transaction_type_wr      = grant_rd || grant_wr;
    assign bus.transaction_type_wr_data = grant_wr ? {2'd2, bus.s_axi_awaddr[3]} :
                                          grant_rd ? {2'd1, bus.s_axi_araddr[3]} : 3'd0;

    assign flit_acc          = (state_q != IDLE) && bus.noc_ready_in;
    assign bus.noc_valid_out = (state_q != IDLE);
    assign bus.busy          = (state_q != IDLE) || (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        rd_pri_d   = rd_pri_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        is_store_d = is_store_q;
        idx_d      = idx_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    addr_d     = bus.s_axi_araddr;
                    is_store_d = 1'b0;
                    rd_pri_d   = !rd_pri_q;
                    state_d    = HDR0;
                end else if (grant_wr) begin
                    addr_d     = bus.s_axi_awaddr;
                    wdata_d    = bus.s_axi_wdata;
                    wstrb_d    = bus.s_axi_wstrb;
                    is_store_d = 1'b1;
                    rd_pri_d   = !rd_pri_q;
                    state_d    = HDR0;
                end
            end
            HDR0: if (flit_acc) state_d = HDR1;
            HDR1: if (flit_acc) state_d = HDR2;
            HDR2: begin
                if (flit_acc) begin
                    idx_d   = '0;
                    state_d = is_store_q ? DATA : IDLE;
                end
            end
            DATA: begin
                if (flit_acc) begin
                    if (int'(idx_q) == DATA_FLITS - 1) state_d = IDLE;
                    else                               idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A retire with nothing outstanding is dropped rather than wrapping the counter.
    always_comb begin
        inc = grant_rd || grant_wr;
        dec = bus.txn_retire && (cnt_q != '0);
        unique case ({inc, dec})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        size_lg  = OFF_W;
        byte_off = '0;
`ifdef AXI_NOC_WSTRB_SIZE_EN
        if (is_store_q) begin
            for (int lg = 0; lg < 4; lg++)
                for (int o = 0; o < STRB_W; o++)
                    if (o + (1 << lg) <= STRB_W && (o % (1 << lg)) == 0 &&
                        wstrb_q == run_mask(lg, o)) begin
                        size_lg  = lg;
                        byte_off = OFF_W'(o);
                    end
        end
`endif
        msg_addr              = addr_q[39:0];
        msg_addr[OFF_W-1:0]   = byte_off;
    end

    // The flit depends only on registered state, never on noc_ready_in.
    always_comb begin
        flit       = '0;
        data_slice = wdata_q[int'(idx_q)*NOC_W +: NOC_W];
        unique case (state_q)
            HDR0: begin
                flit[`MSG_DST_CHIPID] = DEST_CHIPID;
                flit[`MSG_DST_X]      = DEST_X;
                flit[`MSG_DST_Y]      = DEST_Y;
                flit[`MSG_DST_FBITS]  = DEST_FBITS;
                flit[`MSG_LENGTH]     = is_store_q ? STORE_LEN : LOAD_LEN;
                flit[`MSG_TYPE]       = is_store_q ? `MSG_TYPE_NC_STORE_REQ : `MSG_TYPE_NC_LOAD_REQ;
            end
            HDR1: flit[`MSG_ADDR_] = msg_addr;
            HDR2: begin
                flit[`MSG_SRC_CHIPID_] = SRC_CHIPID;
                flit[`MSG_SRC_X_]      = SRC_X;
                flit[`MSG_SRC_Y_]      = SRC_Y;
                flit[`MSG_DATA_SIZE_]  = 3'(size_lg + 1);
            end
            DATA:    flit = {<<8{data_slice}};
            default: flit = '0;
        endcase
    end

    assign bus.noc_data_out = flit;

`ifdef AXI_NOC_WSTRB_SIZE_EN
    assign unused_bits = ^addr_q;
`else
    assign unused_bits = ^{addr_q, wstrb_q};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_pri_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_pri_q <= rd_pri_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: request payload registers carry no reset; they are loaded on acceptance before any read.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        wstrb_q    <= wstrb_d;
        is_store_q <= is_store_d;
        idx_q      <= idx_d;
    end

endmodule

// File: tb/tb_axilite_noc_request.sv
// Directed bench for axilite_noc_request: a queue-based message model checked every cycle,
// plus literal flit/type expectations for the basic load, store, stall and wstrb cases.
module tb_axilite_noc_request;
    localparam int AW = 64, DW = 64, NW = 64, MAXO = 16;

    localparam logic [63:0] H0_LOAD  = 64'h0000_0000_8083_8000;
    localparam logic [63:0] H0_STORE = 64'h0000_0000_80C3_C000;
    localparam logic [63:0] H1_48    = 64'h0000_8000_0048_0000;
    localparam logic [63:0] H1_10    = 64'h0000_8000_0010_0000;
    localparam logic [63:0] H2_FULL  = 64'h0000_0000_2000_0000;
    localparam logic [63:0] D_REV    = 64'h8877_6655_4433_2211;
`ifdef AXI_NOC_WSTRB_SIZE_EN
    localparam logic [63:0] H1_STRB  = 64'h0000_8000_0002_0000;
    localparam logic [63:0] H2_STRB  = 64'h0000_0000_1000_0000;
`else
    localparam logic [63:0] H1_STRB  = 64'h0000_8000_0000_0000;
    localparam logic [63:0] H2_STRB  = 64'h0000_0000_2000_0000;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axilite_noc_request_if #(.ADDR_W(AW), .DATA_W(DW), .NOC_W(NW)) bus ();

    axilite_noc_request #(
        .AXI_LITE_ADDR_WIDTH(AW), .AXI_LITE_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_rd_pri = 1'b1;
    logic [63:0] seen_flit[$];
    logic [2:0]  seen_push[$];

    function automatic int size_code(input int bytes);
        case (bytes)
            1: return 1;
            2: return 2;
            4: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic model_msg(input bit store, input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s);
        int bytes, off, len, typ;
        logic [63:0] addr, rev;
        bytes = 8; off = 0;
`ifdef AXI_NOC_WSTRB_SIZE_EN
        if (store)
            for (int sz = 1; sz <= 8; sz = sz * 2)
                for (int o = 0; o < 8; o = o + sz)
                    if (32'(s) == (((1 << sz) - 1) << o)) begin bytes = sz; off = o; end
`endif
        len  = store ? 3 : 2;
        typ  = store ? 15 : 14;
        addr = (a & ~64'h7) | 64'(off);
        exp_q.push_back((64'd2 << 30) | (64'(len) << 22) | (64'(typ) << 14));
        exp_q.push_back((addr & 64'hFF_FFFF_FFFF) << 16);
        exp_q.push_back(64'(size_code(bytes)) << 27);
        if (store) begin
            rev = {<<8{d}};
            exp_q.push_back(rev);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit idle, can, wc, rc, grd, gwr;
        idle = (exp_q.size() == 0);
        can  = idle && (m_cnt < MAXO) && !reset;
        wc   = bus.s_axi_awvalid && bus.s_axi_wvalid;
        rc   = bus.s_axi_arvalid;
        grd  = can && rc && (!wc || m_rd_pri);
        gwr  = can && wc && (!rc || !m_rd_pri);
        check("arready", 64'(bus.s_axi_arready), 64'(grd));
        check("awready", 64'(bus.s_axi_awready), 64'(gwr));
        check("wready",  64'(bus.s_axi_wready),  64'(gwr));
        check("type_wr", 64'(bus.transaction_type_wr), 64'(grd || gwr));
        if (grd) check("type_data_rd", 64'(bus.transaction_type_wr_data), 64'({2'd1, bus.s_axi_araddr[3]}));
        if (gwr) check("type_data_wr", 64'(bus.transaction_type_wr_data), 64'({2'd2, bus.s_axi_awaddr[3]}));
        check("noc_valid", 64'(bus.noc_valid_out), 64'(!idle));
        if (!idle) check("noc_data", bus.noc_data_out, exp_q[0]);
        check("busy", 64'(bus.busy), 64'(!idle || m_cnt != 0));

        if (bus.transaction_type_wr) seen_push.push_back(bus.transaction_type_wr_data);
        if (bus.noc_valid_out && bus.noc_ready_in) seen_flit.push_back(bus.noc_data_out);

        if (reset) begin
            exp_q.delete();
            m_cnt = 0;
            m_rd_pri = 1'b1;
        end else begin
            if (!idle && bus.noc_ready_in) void'(exp_q.pop_front());
            if (grd) model_msg(1'b0, bus.s_axi_araddr, 64'd0, 8'd0);
            if (gwr) model_msg(1'b1, bus.s_axi_awaddr, bus.s_axi_wdata, bus.s_axi_wstrb);
            if (grd || gwr) m_rd_pri = !m_rd_pri;
            if (grd || gwr) m_cnt++;
            if (bus.txn_retire && m_cnt > 0 && !(grd || gwr)) m_cnt--;
            else if (bus.txn_retire && m_cnt > 0 && (grd || gwr)) m_cnt--;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [63:0] a);
        bit got;
        got = 1'b0;
        bus.s_axi_araddr  = a;
        bus.s_axi_arvalid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = bus.s_axi_arready;
        end
        check("read_grant_in_time", 64'(got), 64'd1);
        tick();
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        bit got;
        got = 1'b0;
        bus.s_axi_awaddr  = a;
        bus.s_axi_wdata   = d;
        bus.s_axi_wstrb   = s;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = bus.s_axi_awready && bus.s_axi_wready;
        end
        check("write_grant_in_time", 64'(got), 64'd1);
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
    endtask

    task automatic do_both(input logic [63:0] ra, input logic [63:0] wa);
        bit rg, wg, r_now, w_now;
        rg = 1'b0; wg = 1'b0;
        bus.s_axi_araddr = ra; bus.s_axi_awaddr = wa;
        bus.s_axi_wdata = 64'h0102_0304_0506_0708; bus.s_axi_wstrb = 8'hFF;
        bus.s_axi_arvalid = 1'b1; bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        for (int i = 0; i < 200 && !(rg && wg); i++) begin
            @(negedge clk);
            r_now = bus.s_axi_arready;
            w_now = bus.s_axi_awready;
            tick();
            if (r_now) begin rg = 1'b1; bus.s_axi_arvalid = 1'b0; end
            if (w_now) begin wg = 1'b1; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; end
        end
        check("both_granted", 64'({rg, wg}), 64'b11);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit blocked, got;
        bus.s_axi_awaddr = '0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_araddr = '0;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
        bus.noc_ready_in = 1'b1; bus.txn_retire = 1'b0;

        // Reset state with all requests pending
        repeat (2) tick();
        @(negedge clk);
        check("rst_arready", 64'(bus.s_axi_arready), 64'd0);
        check("rst_awready", 64'(bus.s_axi_awready), 64'd0);
        check("rst_type_wr", 64'(bus.transaction_type_wr), 64'd0);
        check("rst_noc_valid", 64'(bus.noc_valid_out), 64'd0);
        check("rst_noc_data", bus.noc_data_out, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        tick();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        reset = 1'b0;
        tick();

        // Single load
        seen_flit.delete(); seen_push.delete();
        do_read(64'h8000_0048);
        repeat (4) tick();
        check("ld_nflits", 64'(seen_flit.size()), 64'd3);
        if (seen_flit.size() == 3) begin
            check("ld_hdr0", seen_flit[0], H0_LOAD);
            check("ld_hdr1", seen_flit[1], H1_48);
            check("ld_hdr2", seen_flit[2], H2_FULL);
        end
        check("ld_npush", 64'(seen_push.size()), 64'd1);
        if (seen_push.size() == 1) check("ld_push", 64'(seen_push[0]), 64'(3'b011));

        // Single store
        seen_flit.delete(); seen_push.delete();
        do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
        repeat (5) tick();
        check("st_nflits", 64'(seen_flit.size()), 64'd4);
        if (seen_flit.size() == 4) begin
            check("st_hdr0", seen_flit[0], H0_STORE);
            check("st_hdr1", seen_flit[1], H1_10);
            check("st_hdr2", seen_flit[2], H2_FULL);
            check("st_data", seen_flit[3], D_REV);
        end
        check("st_npush", 64'(seen_push.size()), 64'd1);
        if (seen_push.size() == 1) check("st_push", 64'(seen_push[0]), 64'(3'b100));

        // Contested read/write, twice
        seen_push.delete();
        do_both(64'h100, 64'h200);
        do_both(64'h108, 64'h208);
        repeat (6) tick();
        check("rr_npush", 64'(seen_push.size()), 64'd4);
        if (seen_push.size() == 4) begin
            check("rr_push0", 64'(seen_push[0]), 64'(3'b010));
            check("rr_push1", 64'(seen_push[1]), 64'(3'b100));
            check("rr_push2", 64'(seen_push[2]), 64'(3'b011));
            check("rr_push3", 64'(seen_push[3]), 64'(3'b101));
        end

        // Outstanding limit, with a retire at zero first
        pulse_reset();
        bus.txn_retire = 1'b1;
        tick();
        bus.txn_retire = 1'b0;
        for (int i = 0; i < MAXO; i++) do_read(64'h8000_0000 + 64'(i * 8));
        bus.s_axi_araddr = 64'h8000_1000;
        bus.s_axi_arvalid = 1'b1;
        blocked = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.s_axi_arready) blocked = 1'b0;
        end
        check("full_blocks_ar", 64'(blocked), 64'd1);
        tick();
        bus.txn_retire = 1'b1;
        tick();
        bus.txn_retire = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.s_axi_arready;
        end
        check("retire_unblocks_ar", 64'(got), 64'd1);
        tick();
        bus.s_axi_arvalid = 1'b0;
        repeat (4) tick();

        // Back-pressure during HDR1
        pulse_reset();
        seen_flit.delete();
        do_read(64'h8000_0048);
        tick();
        bus.noc_ready_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.noc_valid_out), 64'd1);
            check("stall_hdr1", bus.noc_data_out, H1_48);
        end
        tick();
        bus.noc_ready_in = 1'b1;
        repeat (4) tick();
        check("stall_nflits", 64'(seen_flit.size()), 64'd3);

        // Partial strobe store
        pulse_reset();
        seen_flit.delete();
        do_write(64'h8000_0000, 64'h1122_3344_5566_7788, 8'b0000_1100);
        repeat (5) tick();
        check("strb_nflits", 64'(seen_flit.size()), 64'd4);
        if (seen_flit.size() == 4) begin
            check("strb_hdr1", seen_flit[1], H1_STRB);
            check("strb_hdr2", seen_flit[2], H2_STRB);
        end

        // Reset in the middle of a store
        bus.noc_ready_in = 1'b0;
        do_write(64'h8000_0020, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        repeat (2) tick();
        pulse_reset();
        bus.noc_ready_in = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(bus.noc_valid_out), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
